cci_mpf_shim_active_limit: RTL and testbench



---
 rtl/cci_mpf_shim_active_limit_if.sv | 21 ++
 rtl/cci_mpf_shim_active_limit.sv | 69 ++++++
 tb/tb_cci_mpf_shim_active_limit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_shim_active_limit_if.sv
// cci_mpf_shim_active_limit_if: AFU request, FIU back-pressure and response bundle
interface cci_mpf_shim_active_limit_if #(
    parameter int N_CHANNELS = 2
);
    logic [N_CHANNELS-1:0]   afu_req_valid;
    logic [2*N_CHANNELS-1:0] afu_req_len;
    logic [N_CHANNELS-1:0]   afu_almost_full;
    logic [N_CHANNELS-1:0]   fiu_req_valid;
    logic [2*N_CHANNELS-1:0] fiu_req_len;
    logic [N_CHANNELS-1:0]   fiu_almost_full;
    logic [N_CHANNELS-1:0]   rsp_valid;
    logic [2*N_CHANNELS-1:0] rsp_cnt;
    modport master (
        output afu_req_valid, afu_req_len, fiu_almost_full, rsp_valid, rsp_cnt,
        input  afu_almost_full, fiu_req_valid, fiu_req_len
    );
    modport slave (
        input  afu_req_valid, afu_req_len, fiu_almost_full, rsp_valid, rsp_cnt,
        output afu_almost_full, fiu_req_valid, fiu_req_len
    );
endinterface

// File: rtl/cci_mpf_shim_active_limit.sv
// cci_mpf_shim_active_limit: per-channel in-flight line counter driving AFU almost-full
module cci_mpf_shim_active_limit #(
    parameter int N_CHANNELS        = 2,
    parameter int MAX_ACTIVE_REQS   = 128,
    parameter int ALMOST_FULL_SLACK = 8,
    parameter int CNT_W             = $clog2(MAX_ACTIVE_REQS + 4*ALMOST_FULL_SLACK + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    cci_mpf_shim_active_limit_if.slave    bus,
    input  logic [CNT_W-1:0]              limit,
    output logic [CNT_W*N_CHANNELS-1:0]   active_cnt,
    output logic [N_CHANNELS-1:0]         error_overflow,
    output logic [N_CHANNELS-1:0]         error_underflow
);
    typedef logic [CNT_W:0] wide_t;
    localparam wide_t MAX_W   = wide_t'(MAX_ACTIVE_REQS);
    localparam wide_t SLACK_W = wide_t'(4*ALMOST_FULL_SLACK);
    localparam wide_t ONE_W   = wide_t'(1);
    wide_t limit_w, limit_eff, thresh;
    // effective limit and threshold; floor of 1 keeps an empty channel from blocking itself
    always_comb begin
        limit_w   = {1'b0, limit};
        limit_eff = (limit_w == '0 || limit_w > MAX_W) ? MAX_W : limit_w;
        thresh    = (limit_eff > SLACK_W) ? limit_eff - SLACK_W : ONE_W;
    end
    // request path is a plain one-cycle register with no stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.fiu_req_valid <= '0;
            bus.fiu_req_len   <= '0;
        end else begin
            bus.fiu_req_valid <= bus.afu_req_valid;
            bus.fiu_req_len   <= bus.afu_req_len;
        end
    end
    for (genvar g = 0; g < N_CHANNELS; g++) begin : gen_ch
        wide_t            req_lines, rsp_lines, sum, diff;
        logic [CNT_W-1:0] cnt, cnt_next;
        logic             under, af, ovf, unf;
        // net requests against retirements, saturating at zero and at all-ones
        always_comb begin
            req_lines = bus.afu_req_valid[g] ? wide_t'(bus.afu_req_len[2*g +: 2]) + ONE_W : '0;
            rsp_lines = bus.rsp_valid[g] ? wide_t'(bus.rsp_cnt[2*g +: 2]) + ONE_W : '0;
            sum       = {1'b0, cnt} + req_lines;
            under     = sum < rsp_lines;
            diff      = sum - rsp_lines;
            cnt_next  = under ? '0 : (diff[CNT_W] ? '1 : diff[CNT_W-1:0]);
        end
        // count, registered almost-full and sticky error flags; almost-full held high in reset
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                af  <= 1'b1;
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                cnt <= cnt_next;
                af  <= bus.fiu_almost_full[g] | ({1'b0, cnt_next} >= thresh);
                ovf <= ovf | ({1'b0, cnt_next} > limit_eff);
                unf <= unf | under;
            end
        end
        assign active_cnt[g*CNT_W +: CNT_W] = cnt;
        assign bus.afu_almost_full[g]       = af;
        assign error_overflow[g]            = ovf;
        assign error_underflow[g]           = unf;
    end
endmodule

// File: tb/tb_cci_mpf_shim_active_limit.sv
// tb_cci_mpf_shim_active_limit: directed self-checking bench for the active-line limiter
module tb_cci_mpf_shim_active_limit;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  limit;
    logic [15:0] active_cnt;
    logic [1:0]  error_overflow, error_underflow;
    int          checks = 0;
    int          failures = 0;
    int          fwd;
    cci_mpf_shim_active_limit_if #(.N_CHANNELS(2)) bus ();
    cci_mpf_shim_active_limit dut (
        .clk(clk), .reset(reset), .bus(bus), .limit(limit),
        .active_cnt(active_cnt), .error_overflow(error_overflow), .error_underflow(error_underflow)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic idle();
        bus.afu_req_valid = '0;
        bus.afu_req_len   = '0;
        bus.rsp_valid     = '0;
        bus.rsp_cnt       = '0;
    endtask
    initial begin
        reset = 1'b1;
        limit = 8'd0;
        bus.fiu_almost_full = '0;
        idle();
        tick();
        tick();
        chk("rst_af", bus.afu_almost_full, 2'b11);
        chk("rst_fiu_valid", bus.fiu_req_valid, 2'b00);
        chk("rst_cnt", active_cnt, 16'd0);
        chk("rst_err", {error_overflow, error_underflow}, 4'b0000);
        reset = 1'b0;
        tick();
        chk("release_af", bus.afu_almost_full, 2'b00);
        bus.afu_req_valid = 2'b01;
        bus.afu_req_len   = 4'b0011;
        for (int i = 0; i < 23; i++) tick();
        chk("pre_thresh_cnt", active_cnt[7:0], 8'd92);
        chk("pre_thresh_af", bus.afu_almost_full, 2'b00);
        tick();
        idle();
        chk("thresh_cnt0", active_cnt[7:0], 8'd96);
        chk("thresh_cnt1", active_cnt[15:8], 8'd0);
        chk("thresh_af", bus.afu_almost_full, 2'b01);
        chk("fiu_copy", {bus.fiu_req_valid, bus.fiu_req_len}, 6'b01_0011);
        tick();
        chk("idle_fiu_valid", bus.fiu_req_valid, 2'b00);
        bus.rsp_valid = 2'b01;
        bus.rsp_cnt   = 4'b0000;
        tick();
        chk("below_cnt", active_cnt[7:0], 8'd95);
        chk("below_af", bus.afu_almost_full, 2'b00);
        bus.rsp_cnt = 4'b0011;
        for (int i = 0; i < 11; i++) tick();
        bus.rsp_cnt = 4'b0000;
        tick();
        chk("at50", active_cnt[7:0], 8'd50);
        bus.afu_req_valid = 2'b01;
        bus.afu_req_len   = 4'b0011;
        bus.rsp_cnt       = 4'b0001;
        tick();
        idle();
        chk("net_cnt", active_cnt[7:0], 8'd52);
        chk("net_err", {error_overflow, error_underflow}, 4'b0000);
        bus.rsp_valid = 2'b01;
        bus.rsp_cnt   = 4'b0011;
        for (int i = 0; i < 13; i++) tick();
        idle();
        chk("drain_cnt", active_cnt[7:0], 8'd0);
        chk("drain_unf", error_underflow, 2'b00);
        limit = 8'd16;
        bus.afu_req_valid = 2'b01;
        tick();
        idle();
        chk("small_cnt", active_cnt[7:0], 8'd1);
        chk("small_af", bus.afu_almost_full, 2'b01);
        limit = 8'd200;
        tick();
        chk("lim200_af", bus.afu_almost_full, 2'b00);
        chk("lim200_cnt", active_cnt[7:0], 8'd1);
        bus.afu_req_valid = 2'b01;
        bus.afu_req_len   = 4'b0011;
        for (int i = 0; i < 24; i++) tick();
        idle();
        chk("lim200_cnt97", active_cnt[7:0], 8'd97);
        chk("lim200_af97", bus.afu_almost_full, 2'b01);
        chk("lim200_ovf", error_overflow, 2'b00);
        bus.rsp_valid = 2'b01;
        bus.rsp_cnt   = 4'b0011;
        for (int i = 0; i < 24; i++) tick();
        bus.rsp_cnt = 4'b0000;
        tick();
        idle();
        chk("lim200_drain", active_cnt[7:0], 8'd0);
        limit = 8'd0;
        fwd = 0;
        bus.afu_req_valid = 2'b01;
        bus.afu_req_len   = 4'b0011;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.fiu_req_valid[0]) fwd++;
        end
        chk("ovf_at128", error_overflow, 2'b00);
        tick();
        if (bus.fiu_req_valid[0]) fwd++;
        idle();
        chk("ovf_cnt", active_cnt[7:0], 8'd132);
        chk("ovf_flag", error_overflow, 2'b01);
        chk("ovf_fwd", fwd, 33);
        bus.rsp_valid = 2'b01;
        bus.rsp_cnt   = 4'b0011;
        for (int i = 0; i < 33; i++) tick();
        idle();
        chk("ovf_drain_cnt", active_cnt[7:0], 8'd0);
        chk("ovf_sticky", error_overflow, 2'b01);
        chk("ovf_no_unf", error_underflow, 2'b00);
        bus.afu_req_valid = 2'b10;
        tick();
        idle();
        chk("ch1_cnt1", active_cnt[15:8], 8'd1);
        bus.rsp_valid = 2'b10;
        bus.rsp_cnt   = 4'b1000;
        tick();
        idle();
        chk("unf_cnt", active_cnt[15:8], 8'd0);
        chk("unf_flag", error_underflow, 2'b10);
        tick();
        chk("unf_sticky", error_underflow, 2'b10);
        chk("ovf_still", error_overflow, 2'b01);
        bus.fiu_almost_full = 2'b10;
        tick();
        chk("fiu_af", bus.afu_almost_full, 2'b10);
        bus.fiu_almost_full = 2'b00;
        tick();
        chk("fiu_af_clr", bus.afu_almost_full, 2'b00);
        bus.afu_req_valid = 2'b11;
        bus.afu_req_len   = 4'b0101;
        tick();
        idle();
        chk("pre_rst_cnt", active_cnt, {8'd2, 8'd2});
        reset = 1'b1;
        #1;
        chk("async_cnt", active_cnt, 16'd0);
        chk("async_af", bus.afu_almost_full, 2'b11);
        chk("async_err", {error_overflow, error_underflow}, 4'b0000);
        #2;
        reset = 1'b0;
        tick();
        chk("rerelease_af", bus.afu_almost_full, 2'b00);
        bus.rsp_valid = 2'b01;
        tick();
        idle();
        chk("late_rsp_unf", error_underflow, 2'b01);
        chk("late_rsp_cnt", active_cnt[7:0], 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
